// File: rtl/ysyx_23060061_lsu.sv
// Multi-cycle load/store unit: turns one core access into a word-aligned bus
// transaction with byte strobes and returns aligned, extended load data.
module ysyx_23060061_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  MemRW,
    input  logic [2:0]  memExt,
    input  logic [3:0]  wmask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_resp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    logic [1:0]  state_reg, state_next;
    logic [1:0]  offset_reg;
    logic [2:0]  ext_reg;
    logic [31:0] tmo_cnt_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;
    logic [31:0] bus_addr_reg, bus_wdata_reg;
    logic [3:0]  bus_wstrb_reg;
    logic        bus_we_reg;

    logic        is_half, is_word, misaligned, bypass_bus, timeout_hit;
    logic [7:0]  strb_wide;
    logic [31:0] wdata_shift, rd_shift, rd_ext;

    // Access size: stores take it from the strobe mask, loads from the extension code.
    always_comb begin
        is_half = 1'b0;
        is_word = 1'b0;
        if (MemRW == 2'b01) begin
            is_word = (wmask == 4'b1111);
            is_half = (wmask == 4'b0011);
        end else begin
            case (memExt)
                3'b001, 3'b011: ;
                3'b010, 3'b100: is_half = 1'b1;
                default:        is_word = 1'b1;
            endcase
        end
    end

    assign misaligned  = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    assign bypass_bus  = (MemRW == 2'b00) || (MemRW == 2'b11) || misaligned;
    assign strb_wide   = {4'b0000, wmask} << addr[1:0];
    assign wdata_shift = wdata << {addr[1:0], 3'b000};
    assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt_reg == TIMEOUT_LAST);

    assign rd_shift = bus_rdata >> {offset_reg, 3'b000};

    always_comb begin
        case (ext_reg)
            3'b001:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b010:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b011:  rd_ext = {24'h000000, rd_shift[7:0]};
            3'b100:  rd_ext = {16'h0000, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (req_valid) state_next = bypass_bus ? RESP : REQ;
            REQ:  if (bus_req_ready) state_next = WAIT;
            WAIT: if (bus_resp_valid || timeout_hit) state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            offset_reg    <= 2'b00;
            ext_reg       <= 3'b000;
            tmo_cnt_reg   <= 32'd0;
            rdata_reg     <= 32'd0;
            err_reg       <= 1'b0;
            bus_addr_reg  <= 32'd0;
            bus_wdata_reg <= 32'd0;
            bus_wstrb_reg <= 4'b0000;
            bus_we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        offset_reg    <= addr[1:0];
                        ext_reg       <= memExt;
                        bus_addr_reg  <= {addr[31:2], 2'b00};
                        bus_we_reg    <= (MemRW == 2'b01);
                        bus_wdata_reg <= wdata_shift;
                        bus_wstrb_reg <= (MemRW == 2'b01) ? strb_wide[3:0] : 4'b0000;
                        err_reg       <= (MemRW == 2'b11) || ((MemRW != 2'b00) && misaligned);
                        rdata_reg     <= 32'd0;
                    end
                end
                REQ: begin
                    if (bus_req_ready) tmo_cnt_reg <= 32'd0;
                end
                WAIT: begin
                    if (bus_resp_valid) begin
                        err_reg   <= bus_resp_err;
                        rdata_reg <= (bus_resp_err || bus_we_reg) ? 32'd0 : rd_ext;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
                        if (timeout_hit) begin
                            err_reg   <= 1'b1;
                            rdata_reg <= 32'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (state_reg == IDLE);
    assign resp_valid    = (state_reg == RESP);
    assign resp_rdata    = rdata_reg;
    assign resp_err      = err_reg;
    assign bus_req_valid = (state_reg == REQ);
    assign bus_we        = bus_we_reg;
    assign bus_addr      = bus_addr_reg;
    assign bus_wdata     = bus_wdata_reg;
    assign bus_wstrb     = bus_wstrb_reg;

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// Directed bench for the load/store unit: loads, stores, error bypass,
// request backpressure, response timeout and reset during a transaction.
module tb_ysyx_23060061_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  MemRW = 2'b00;
    logic [2:0]  memExt = 3'b000;
    logic [3:0]  wmask = 4'b0000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b1;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_resp_valid = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_resp_err = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the last run_access call
    int          obs_lat;
    logic [31:0] obs_rd, obs_addr, obs_wdata;
    logic [3:0]  obs_strb;
    logic        obs_err, obs_we, obs_saw_req, obs_rv_after;

    ysyx_23060061_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .MemRW(MemRW), .memExt(memExt), .wmask(wmask), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Issues one access with a ready bus that answers in the first WAIT cycle.
    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_access(input logic [1:0] rw, input logic [2:0] ext, input logic [3:0] mask,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] brd, input logic berr);
        logic hs;
        hs = 1'b0;
        obs_saw_req = 1'b0; obs_rd = 32'hx; obs_err = 1'bx; obs_lat = -1;
        obs_addr = 32'hx; obs_wdata = 32'hx; obs_strb = 4'hx; obs_we = 1'bx;
        bus_req_ready = 1'b1; bus_rdata = brd; bus_resp_err = berr;
        MemRW = rw; memExt = ext; wmask = mask; addr = a; wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (resp_valid) begin
                obs_lat = c; obs_rd = resp_rdata; obs_err = resp_err;
                break;
            end
            if (bus_req_valid && !obs_saw_req) begin
                obs_saw_req = 1'b1; obs_addr = bus_addr; obs_wdata = bus_wdata;
                obs_strb = bus_wstrb; obs_we = bus_we;
            end
            bus_resp_valid = hs;
            hs = bus_req_valid && bus_req_ready;
            @(posedge clk); #1;
        end
        bus_resp_valid = 1'b0;
        @(posedge clk); #1;
        obs_rv_after = resp_valid;
        $display("txn rw=%b ext=%b mask=%b addr=%h wdata=%h -> lat=%0d rdata=%h err=%b",
                 rw, ext, mask, a, wd, obs_lat, obs_rd, obs_err);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        n_checks++; if (bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req_valid: got %b want 0", bus_req_valid); end
        n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we: got %b want 0", bus_we); end
        n_checks++; if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
        n_checks++; if (bus_addr !== 32'd0 || bus_wdata !== 32'd0 || bus_wstrb !== 4'd0) begin
            n_fail++; $display("FAIL reset_bus_fields: got addr=%h wdata=%h strb=%b want zeros", bus_addr, bus_wdata, bus_wstrb);
        end
        rst = 1'b0;
        bus_rdata = 32'h12345678; bus_resp_valid = 1'b1;
        @(posedge clk); #1;
        bus_resp_valid = 1'b0;
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL stray_resp_after_reset: got resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_resp_after_reset2: got %b want 0", resp_valid); end
    endtask

    task automatic test_load_word;
        run_access(2'b10, 3'b000, 4'b0000, 32'h80000004, 32'h0, 32'hDEADBEEF, 1'b0);
        n_checks++; if (obs_lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", obs_lat); end
        n_checks++; if (obs_addr !== 32'h80000004) begin n_fail++; $display("FAIL lw_bus_addr: got %h want 80000004", obs_addr); end
        n_checks++; if (obs_strb !== 4'b0000 || obs_we !== 1'b0) begin
            n_fail++; $display("FAIL lw_strb_we: got strb=%b we=%b want 0000/0", obs_strb, obs_we);
        end
        n_checks++; if (obs_rd !== 32'hDEADBEEF || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL lw_data: got %h err=%b want deadbeef err=0", obs_rd, obs_err);
        end
        n_checks++; if (obs_rv_after !== 1'b0) begin n_fail++; $display("FAIL lw_one_cycle_pulse: got %b want 0", obs_rv_after); end
    endtask

    task automatic test_load_ext;
        logic [2:0]  ext_t  [4] = '{3'b001, 3'b011, 3'b010, 3'b100};
        logic [31:0] addr_t [4] = '{32'h80000003, 32'h80000003, 32'h80000002, 32'h80000002};
        logic [31:0] exp_t  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        for (int i = 0; i < 4; i++) begin
            run_access(2'b10, ext_t[i], 4'b0000, addr_t[i], 32'h0, 32'h80FF1234, 1'b0);
            n_checks++; if (obs_rd !== exp_t[i] || obs_err !== 1'b0 || obs_lat !== 3) begin
                n_fail++; $display("FAIL load_ext_%0d: got %h err=%b lat=%0d want %h err=0 lat=3", i, obs_rd, obs_err, obs_lat, exp_t[i]);
            end
            n_checks++; if (obs_addr !== 32'h80000000) begin n_fail++; $display("FAIL load_ext_addr_%0d: got %h want 80000000", i, obs_addr); end
        end
    endtask

    task automatic test_store;
        logic [31:0] addr_t [3] = '{32'h10000001, 32'h10000002, 32'h10000000};
        logic [31:0] wd_t   [3] = '{32'h000000AB, 32'h00001234, 32'hCAFEF00D};
        logic [3:0]  mask_t [3] = '{4'b0001, 4'b0011, 4'b1111};
        logic [31:0] expw_t [3] = '{32'h0000AB00, 32'h12340000, 32'hCAFEF00D};
        logic [3:0]  exps_t [3] = '{4'b0010, 4'b1100, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            run_access(2'b01, 3'b000, mask_t[i], addr_t[i], wd_t[i], 32'hFFFFFFFF, 1'b0);
            n_checks++; if (obs_wdata !== expw_t[i] || obs_strb !== exps_t[i] || obs_we !== 1'b1) begin
                n_fail++; $display("FAIL store_lanes_%0d: got wdata=%h strb=%b we=%b want %h %b 1", i, obs_wdata, obs_strb, obs_we, expw_t[i], exps_t[i]);
            end
            n_checks++; if (obs_addr !== 32'h10000000) begin n_fail++; $display("FAIL store_addr_%0d: got %h want 10000000", i, obs_addr); end
            n_checks++; if (obs_rd !== 32'd0 || obs_err !== 1'b0 || obs_lat !== 3) begin
                n_fail++; $display("FAIL store_resp_%0d: got rdata=%h err=%b lat=%0d want 0 0 3", i, obs_rd, obs_err, obs_lat);
            end
        end
    endtask

    task automatic test_errors;
        logic [1:0]  rw_t   [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [2:0]  ext_t  [4] = '{3'b000, 3'b000, 3'b010, 3'b000};
        logic [3:0]  mask_t [4] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};
        logic [31:0] addr_t [4] = '{32'h10000002, 32'h10000000, 32'h80000001, 32'h80000003};
        logic        err_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_access(rw_t[i], ext_t[i], mask_t[i], addr_t[i], 32'h55AA55AA, 32'hA5A5A5A5, 1'b0);
            n_checks++; if (obs_lat !== 1 || obs_err !== err_t[i] || obs_rd !== 32'd0) begin
                n_fail++; $display("FAIL bypass_%0d: got lat=%0d err=%b rdata=%h want 1 %b 0", i, obs_lat, obs_err, obs_rd, err_t[i]);
            end
            n_checks++; if (obs_saw_req !== 1'b0) begin n_fail++; $display("FAIL bypass_no_bus_%0d: got bus_req=%b want 0", i, obs_saw_req); end
        end
        run_access(2'b10, 3'b000, 4'b0000, 32'h80000008, 32'h0, 32'h11111111, 1'b1);
        n_checks++; if (obs_lat !== 3 || obs_err !== 1'b1 || obs_rd !== 32'd0) begin
            n_fail++; $display("FAIL bus_error: got lat=%0d err=%b rdata=%h want 3 1 0", obs_lat, obs_err, obs_rd);
        end
        bus_resp_err = 1'b0;
    endtask

    task automatic test_backpressure;
        bus_req_ready = 1'b0;
        MemRW = 2'b01; memExt = 3'b000; wmask = 4'b1111; addr = 32'h20000004; wdata = 32'h11223344;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; wdata = 32'hFFFFFFFF; addr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus_req_valid !== 1'b1 || bus_addr !== 32'h20000004 || bus_wdata !== 32'h11223344 ||
                            bus_wstrb !== 4'b1111 || bus_we !== 1'b1) begin
                n_fail++; $display("FAIL backpressure_hold_%0d: got v=%b addr=%h wdata=%h strb=%b we=%b want 1 20000004 11223344 1111 1",
                                   i, bus_req_valid, bus_addr, bus_wdata, bus_wstrb, bus_we);
            end
            @(posedge clk); #1;
        end
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus_req_valid !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_wait: got bus_req_valid=%b resp_valid=%b want 0/0", bus_req_valid, resp_valid);
        end
        bus_resp_valid = 1'b1;
        @(posedge clk); #1;
        bus_resp_valid = 1'b0;
        n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL backpressure_resp: got v=%b err=%b rdata=%h want 1 0 0", resp_valid, resp_err, resp_rdata);
        end
        $display("txn backpressured sw addr=20000004 -> resp_valid=%b err=%b", resp_valid, resp_err);
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        int n;
        bus_req_ready = 1'b1;
        MemRW = 2'b10; memExt = 3'b000; addr = 32'h80000010; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (!resp_valid && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL timeout_cycles: got %0d wait cycles want 4", n); end
        n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL timeout_resp: got v=%b err=%b rdata=%h want 1 1 0", resp_valid, resp_err, resp_rdata);
        end
        $display("txn lw addr=80000010 timeout -> wait=%0d err=%b", n, resp_err);
        @(posedge clk); #1;
        bus_rdata = 32'hBADBAD00; bus_resp_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++; $display("FAIL late_resp_ignored_%0d: got resp_valid=%b req_ready=%b want 0/1", i, resp_valid, req_ready);
            end
        end
        bus_resp_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        bus_req_ready = 1'b1;
        MemRW = 2'b10; memExt = 3'b000; addr = 32'h80000020; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (bus_req_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got bus_req_valid=%b req_ready=%b resp_valid=%b want 0 1 0", bus_req_valid, req_ready, resp_valid);
        end
        bus_rdata = 32'h0BADF00D; bus_resp_valid = 1'b1;
        @(posedge clk); #1;
        bus_resp_valid = 1'b0;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stray: got %b want 0", resp_valid); end
        @(posedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stray2: got %b want 0", resp_valid); end
        run_access(2'b10, 3'b000, 4'b0000, 32'h80000024, 32'h0, 32'h01234567, 1'b0);
        n_checks++; if (obs_lat !== 3 || obs_rd !== 32'h01234567 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_recover: got lat=%0d rdata=%h err=%b want 3 01234567 0", obs_lat, obs_rd, obs_err);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_ext();
        test_store();
        test_errors();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060061_lsu.md
Name: ysyx_23060061_lsu

Overview:
- Multi-cycle load/store unit that executes the memory side of the decoder's control word (MemRW, wmask, memExt).
- Accepts one access per request handshake from the core and converts the byte/half/word request into a word-aligned bus transaction with byte strobes.
- Returns load data aligned and sign/zero extended, ready for the WBSel=00 writeback path.
- Sits between the EXU (ALU result used as address, rs2 as store data) and the data-memory bus.

Parameters:
- TIMEOUT, 255: max cycles waiting for bus_resp_valid after the request handshake; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  core presents an access
- req_ready  output  1  LSU can accept an access
- MemRW  input  2  00 idle, 10 read, 01 write, 11 illegal
- memExt  input  3  000 word, 001 sext byte, 010 sext half, 011 zext byte, 100 zext half; 101-111 treated as 000
- wmask  input  4  store size: 0001 byte, 0011 half, 1111 word
- addr  input  32  byte address
- wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned access, illegal MemRW, bus error or timeout
- bus_req_valid  output  1  bus request
- bus_req_ready  input  1  bus accepts request
- bus_we  output  1  1 write, 0 read
- bus_addr  output  32  {addr[31:2],2'b00}
- bus_wdata  output  32  store data shifted to byte lane
- bus_wstrb  output  4  wmask shifted by addr[1:0]; 0000 on reads
- bus_resp_valid  input  1  bus response
- bus_rdata  input  32  raw read word
- bus_resp_err  input  1  bus error with response

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE, req_ready=1.
  - resp_valid, resp_err, bus_req_valid, bus_we = 0.
  - resp_rdata, bus_addr, bus_wdata = 0; bus_wstrb=0.
  - Timeout counter = 0.
- States: IDLE, REQ, WAIT, RESP. req_ready = (state==IDLE).
- IDLE: accept when req_valid & req_ready, and latch all request fields.
  - MemRW=00: go to RESP with err=0 and rdata=0; no bus traffic.
  - MemRW=11: go to RESP with err=1; no bus traffic.
  - Misaligned access goes to RESP with err=1 and no bus traffic:
    - half access with addr[0]=1;
    - word access with addr[1:0]!=00.
  - Size comes from wmask for writes and from memExt for reads.
  - Otherwise go to REQ.
- REQ:
  - bus_req_valid=1. bus_addr, bus_we, bus_wdata and bus_wstrb are driven from latched values and held stable until bus_req_ready.
  - On bus_req_ready: go to WAIT, clear the counter.
- WAIT:
  - bus_req_valid=0. bus_resp_valid is sampled only in this state.
  - On bus_resp_valid: go to RESP; err=bus_resp_err.
  - Read data on a response: shift bus_rdata >> (8*addr[1:0]), then extend per memExt. resp_rdata is 0 if err.
  - No response: counter increments each cycle. If TIMEOUT!=0 and counter==TIMEOUT-1 with no response, go to RESP with err=1 and rdata=0.
- RESP: resp_valid=1 for exactly one cycle with registered rdata and err, then return to IDLE. There is no core backpressure.
- Lane shifting: bus_wdata = wdata << (8*addr[1:0]); bus_wstrb = wmask << addr[1:0], truncated to 4 bits.
- Latency:
  - Accepted aligned access with bus_req_ready=1 and a response in the first WAIT cycle: resp_valid 3 cycles after acceptance (REQ, WAIT, RESP).
  - Error or idle access: resp_valid 1 cycle after acceptance.
- Boundaries:
  - req_valid while not IDLE is ignored; the core must hold it.
  - bus_resp_valid in IDLE, REQ or RESP is ignored, including a stray response after reset.
  - rst mid-transaction returns to IDLE on that edge and drops bus_req_valid. The outstanding bus response is discarded.
  - A timeout response leaves the bus transaction abandoned; a late response arriving in IDLE is ignored.

Test Plan:
- lw addr=0x80000004, bus_rdata=0xDEADBEEF, bus always ready, 1-cycle response -> bus_addr=0x80000004, bus_wstrb=0000; resp_valid 3 cycles after accept; resp_rdata=0xDEADBEEF, resp_err=0.
- lb addr=0x80000003, bus_rdata=0x80FF1234 -> resp_rdata=0xFFFFFF80. Same access with lbu -> 0x00000080. lh addr=0x80000002 -> 0xFFFF80FF; lhu -> 0x000080FF.
- sb addr=0x10000001, wdata=0x000000AB, wmask=0001 -> bus_wdata=0x0000AB00, bus_wstrb=0010, bus_we=1. sh addr=0x10000002, wmask=0011 -> bus_wstrb=1100.
- Misaligned: sw addr=0x10000002 -> resp_valid next cycle, resp_err=1, bus_req_valid never asserted. Same for MemRW=11.
- Backpressure/timeout: bus_req_ready low 5 cycles -> request fields stable for 5 cycles. TIMEOUT=4 with no response -> resp_err=1 exactly 4 WAIT cycles after the handshake; a later bus_resp_valid is ignored.
- Reset mid-WAIT: rst=1 for one cycle -> bus_req_valid=0, req_ready=1 next cycle. A following bus_resp_valid produces no resp_valid, and a new lw completes normally.
